cache_metadata_flush: RTL and testbench
=======================================

Name: cache_metadata_flush

Overview:
- Generalised set-associative cache tag/valid/dirty store with true-LRU replacement.
- Adds invalid-way-first victim selection and a hardware flush walker.
- The flush walker scans every line, hands dirty lines to the writeback path over a valid/ready handshake, and invalidates all lines.
- Sits between the cache controller FSM and the data array / writeback buffer.

Parameters:
- NUM_SETS, 16, number of sets (power of 2, >=2); SET_SIZE = $clog2(NUM_SETS).
- ASSOC, 4, ways per set (power of 2, >=1); WAY_SIZE = max(1, $clog2(ASSOC)).
- TAG_SIZE, 26, tag width.
- READ_ONLY, 0, 1 removes dirty storage (instruction cache).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- set  in  SET_SIZE  lookup/update set index
- tag  in  TAG_SIZE  lookup/install tag
- miss_recovery_mode  in  1  1: selected_way = victim; 0: selected_way = matching way
- touch  in  1  mark selected_way most-recently-used
- install  in  1  write tag to selected_way, valid=1, dirty=install_dirty
- install_dirty  in  1  dirty value written on install
- invalidate  in  1  clear valid and dirty of selected_way
- set_dirty  in  1  set dirty of selected_way
- clear_dirty  in  1  clear dirty of selected_way
- valid_block_match  out  1  hit in set
- valid_dirty_bit  out  1  selected line valid and dirty
- selected_tag  out  TAG_SIZE  tag stored at set/selected_way
- selected_way  out  WAY_SIZE  hit way or victim way
- flush_req  in  1  start flush (one-cycle pulse)
- flush_busy  out  1  walker active
- flush_wb_valid  out  1  dirty line offered for writeback
- flush_wb_ready  in  1  writeback accepts
- flush_wb_set  out  SET_SIZE  set of offered line
- flush_wb_way  out  WAY_SIZE  way of offered line
- flush_wb_tag  out  TAG_SIZE  tag of offered line
- flush_done  out  1  one-cycle pulse at flush completion

Behaviour:
- Reset:
  - Synchronous, active-high, clock clk.
  - valid=0 and dirty=0 for all lines; LRU ages per set = way index; FSM in IDLE.
  - All flush outputs 0.
  - Tag array is not reset.
- Lookup:
  - Combinational from set/tag.
  - Hit way = the single way with valid & tag match.
  - On a miss with miss_recovery_mode=0, selected_way = 0.
- Victim selection:
  - Lowest-index invalid way in the set.
  - If all ways are valid, the way with maximum age (ASSOC-1).
- State updates: take effect on the next rising edge, at set/selected_way.
- touch:
  - Selected way's age <= 0.
  - Every way in the set whose age < the old age increments.
  - Ages remain a permutation of 0..ASSOC-1.
- Priority on simultaneous strobes:
  - invalidate > install.
  - clear_dirty > set_dirty.
  - install with set_dirty yields dirty=1.
  - touch may coincide with any strobe.
- ASSOC=1: selected_way = 0 and touch has no effect.
- READ_ONLY=1: dirty strobes and install_dirty are ignored; valid_dirty_bit = 0.
- Flush FSM states: IDLE, SCAN, WB, DONE.
  - IDLE: flush_req -> SCAN with walk index (set 0, way 0); flush_busy=1 from the next cycle.
  - SCAN, line valid & dirty: -> WB.
  - SCAN, line not dirty: clear its valid bit; if this is the last index (NUM_SETS-1, ASSOC-1) -> DONE, else increment the index (way first, then set). One line per cycle.
  - WB: flush_wb_valid=1; flush_wb_set/way/tag are held stable until flush_wb_ready.
  - WB handshake (valid & ready): clear valid and dirty; then go to DONE if last index, else SCAN with next index.
  - WB with ready low: stay in WB indefinitely.
  - DONE: flush_done=1 for one cycle; flush_busy=0; return to IDLE.
- While flush_busy:
  - Controller strobes (touch, install, invalidate, set_dirty, clear_dirty) are ignored.
  - valid_block_match forced 0.
  - flush_req is ignored.
- LRU ages are unchanged by a flush.
- Reset mid-flush: immediate return to IDLE with reset values; no flush_done.
- Minimum flush duration with no dirty lines: NUM_SETS*ASSOC SCAN cycles + 1 DONE cycle.

Optional Feature:
- Macro: METADATA_FLUSH_STATS_EN.
- When defined:
  - Adds output flush_wb_count, width SET_SIZE+WAY_SIZE+1.
  - Cleared when a flush starts; increments on each WB handshake.
  - Holds its value after flush_done until the next flush or reset; reset value 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then lookup set 3, tag 0x55 with miss_recovery_mode=0 -> valid_block_match=0, valid_dirty_bit=0, selected_way=0.
- Install tags 0xA, 0xB, 0xC, 0xD into set 5 with miss_recovery_mode=1, touching each -> victims are ways 0,1,2,3 in order. Then touch way 0 via a hit on 0xA; next victim = way 1.
- Install with install_dirty=1 and invalidate in the same cycle on set 2 -> line invalid, valid_dirty_bit=0. Then set_dirty+clear_dirty together on a valid line -> dirty=0.
- Dirty lines at (set 1, way 2) and (set 9, way 0); pulse flush_req; hold flush_wb_ready low for 5 cycles at the first offer:
  - Offer (1,2) is held stable for the whole stall.
  - Second offer is (9,0).
  - flush_done pulses once; all valid bits read 0; flush_wb_count=2 with METADATA_FLUSH_STATS_EN.
- Assert reset while in WB -> next cycle flush_busy=0, flush_wb_valid=0, no flush_done, all lines invalid.
- During flush, drive install for set 0 -> ignored; after flush_done the lookup misses. A flush_req during busy does not restart the walk.

Source files
------------

// File: rtl/cache_metadata_flush_if.sv
// Controller/writeback bundle for cache_metadata_flush.
// The flush_wb_count member exists only when METADATA_FLUSH_STATS_EN is defined.
interface cache_metadata_flush_if #(
  parameter int NUM_SETS = 16,
  parameter int ASSOC    = 4,
  parameter int TAG_SIZE = 26
);
  localparam int SET_SIZE = $clog2(NUM_SETS);
  localparam int WAY_SIZE = (ASSOC > 1) ? $clog2(ASSOC) : 1;

  logic [SET_SIZE-1:0] set;
  logic [TAG_SIZE-1:0] tag;
  logic                miss_recovery_mode;
  logic                touch;
  logic                install;
  logic                install_dirty;
  logic                invalidate;
  logic                set_dirty;
  logic                clear_dirty;
  logic                valid_block_match;
  logic                valid_dirty_bit;
  logic [TAG_SIZE-1:0] selected_tag;
  logic [WAY_SIZE-1:0] selected_way;
  logic                flush_req;
  logic                flush_busy;
  logic                flush_wb_valid;
  logic                flush_wb_ready;
  logic [SET_SIZE-1:0] flush_wb_set;
  logic [WAY_SIZE-1:0] flush_wb_way;
  logic [TAG_SIZE-1:0] flush_wb_tag;
  logic                flush_done;

`ifdef METADATA_FLUSH_STATS_EN
  logic [SET_SIZE+WAY_SIZE:0] flush_wb_count;

  modport master (
    output set, tag, miss_recovery_mode, touch, install, install_dirty,
           invalidate, set_dirty, clear_dirty, flush_req, flush_wb_ready,
    input  valid_block_match, valid_dirty_bit, selected_tag, selected_way,
           flush_busy, flush_wb_valid, flush_wb_set, flush_wb_way,
           flush_wb_tag, flush_done, flush_wb_count
  );
  modport slave (
    input  set, tag, miss_recovery_mode, touch, install, install_dirty,
           invalidate, set_dirty, clear_dirty, flush_req, flush_wb_ready,
    output valid_block_match, valid_dirty_bit, selected_tag, selected_way,
           flush_busy, flush_wb_valid, flush_wb_set, flush_wb_way,
           flush_wb_tag, flush_done, flush_wb_count
  );
`else
  modport master (
    output set, tag, miss_recovery_mode, touch, install, install_dirty,
           invalidate, set_dirty, clear_dirty, flush_req, flush_wb_ready,
    input  valid_block_match, valid_dirty_bit, selected_tag, selected_way,
           flush_busy, flush_wb_valid, flush_wb_set, flush_wb_way,
           flush_wb_tag, flush_done
  );
  modport slave (
    input  set, tag, miss_recovery_mode, touch, install, install_dirty,
           invalidate, set_dirty, clear_dirty, flush_req, flush_wb_ready,
    output valid_block_match, valid_dirty_bit, selected_tag, selected_way,
           flush_busy, flush_wb_valid, flush_wb_set, flush_wb_way,
           flush_wb_tag, flush_done
  );
`endif
endinterface

// File: rtl/cache_metadata_flush.sv
// Set-associative tag/valid/dirty store with true-LRU ages, invalid-first victim
// choice and a flush walker. Optional writeback counter: METADATA_FLUSH_STATS_EN.
module cache_metadata_flush #(
  parameter int NUM_SETS  = 16,
  parameter int ASSOC     = 4,
  parameter int TAG_SIZE  = 26,
  parameter int READ_ONLY = 0
) (
  input logic clk,
  input logic reset,
  cache_metadata_flush_if.slave bus
);
  localparam int SET_SIZE = $clog2(NUM_SETS);
  localparam int WAY_SIZE = (ASSOC > 1) ? $clog2(ASSOC) : 1;
  localparam logic [SET_SIZE-1:0] LAST_SET = SET_SIZE'(NUM_SETS - 1);
  localparam logic [WAY_SIZE-1:0] LAST_WAY = WAY_SIZE'(ASSOC - 1);

  typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;

  state_t              state_q, state_d;
  logic [SET_SIZE-1:0] walk_set_q, walk_set_d;
  logic [WAY_SIZE-1:0] walk_way_q, walk_way_d;

  logic                valid_q [NUM_SETS][ASSOC];
  logic                dirty_q [NUM_SETS][ASSOC];
  logic [TAG_SIZE-1:0] tag_q   [NUM_SETS][ASSOC];
  logic [WAY_SIZE-1:0] age_q   [NUM_SETS][ASSOC];

  logic                hit;
  logic                victim_found;
  logic [WAY_SIZE-1:0] hit_way, victim_way, sel_way;
  logic [WAY_SIZE-1:0] touch_age;
  logic                install_dirty_val;
  logic                busy;
  logic                line_dirty, last_idx;
  logic [SET_SIZE-1:0] nxt_set;
  logic [WAY_SIZE-1:0] nxt_way;
  logic                walk_clr_valid, wb_fire, flush_start;

  // Lookup and victim selection
  always_comb begin
    hit          = 1'b0;
    hit_way      = '0;
    victim_way   = '0;
    victim_found = 1'b0;
    for (int unsigned w = 0; w < ASSOC; w++) begin
      if (valid_q[bus.set][w] && (tag_q[bus.set][w] == bus.tag)) begin
        hit     = 1'b1;
        hit_way = hit_way | WAY_SIZE'(w);
      end
    end
    for (int unsigned w = 0; w < ASSOC; w++) begin
      if (!victim_found && !valid_q[bus.set][w]) begin
        victim_way   = WAY_SIZE'(w);
        victim_found = 1'b1;
      end
    end
    if (!victim_found) begin
      for (int unsigned w = 0; w < ASSOC; w++) begin
        if (age_q[bus.set][w] == LAST_WAY) victim_way = WAY_SIZE'(w);
      end
    end
  end

  assign sel_way           = bus.miss_recovery_mode ? victim_way : (hit ? hit_way : '0);
  assign touch_age         = age_q[bus.set][sel_way];
  assign install_dirty_val = bus.clear_dirty ? 1'b0 : (bus.install_dirty | bus.set_dirty);
  assign busy              = (state_q == SCAN) || (state_q == WB);

  assign bus.selected_way      = sel_way;
  assign bus.selected_tag      = tag_q[bus.set][sel_way];
  assign bus.valid_block_match = hit && !busy;
  assign bus.valid_dirty_bit   = (READ_ONLY == 0) && valid_q[bus.set][sel_way] &&
                                 dirty_q[bus.set][sel_way];

  // Walk index order: way first, then set
  always_comb begin
    line_dirty = valid_q[walk_set_q][walk_way_q] && dirty_q[walk_set_q][walk_way_q];
    last_idx   = (walk_set_q == LAST_SET) && (walk_way_q == LAST_WAY);
    if (walk_way_q == LAST_WAY) begin
      nxt_way = '0;
      nxt_set = walk_set_q + SET_SIZE'(1);
    end else begin
      nxt_way = walk_way_q + WAY_SIZE'(1);
      nxt_set = walk_set_q;
    end
  end

  always_comb begin
    state_d        = state_q;
    walk_set_d     = walk_set_q;
    walk_way_d     = walk_way_q;
    walk_clr_valid = 1'b0;
    wb_fire        = 1'b0;
    flush_start    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          state_d     = SCAN;
          walk_set_d  = '0;
          walk_way_d  = '0;
          flush_start = 1'b1;
        end
      end
      SCAN: begin
        if (line_dirty) begin
          state_d = WB;
        end else begin
          walk_clr_valid = 1'b1;
          if (last_idx) begin
            state_d = DONE;
          end else begin
            walk_set_d = nxt_set;
            walk_way_d = nxt_way;
          end
        end
      end
      WB: begin
        if (bus.flush_wb_ready) begin
          wb_fire        = 1'b1;
          walk_clr_valid = 1'b1;
          if (last_idx) begin
            state_d = DONE;
          end else begin
            state_d    = SCAN;
            walk_set_d = nxt_set;
            walk_way_d = nxt_way;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      walk_set_q <= '0;
      walk_way_q <= '0;
    end else begin
      state_q    <= state_d;
      walk_set_q <= walk_set_d;
      walk_way_q <= walk_way_d;
    end
  end

  assign bus.flush_busy     = busy;
  assign bus.flush_done     = (state_q == DONE);
  assign bus.flush_wb_valid = (state_q == WB);
  assign bus.flush_wb_set   = (state_q == WB) ? walk_set_q : '0;
  assign bus.flush_wb_way   = (state_q == WB) ? walk_way_q : '0;
  assign bus.flush_wb_tag   = (state_q == WB) ? tag_q[walk_set_q][walk_way_q] : '0;

  // Controller strobes and walker clears are mutually exclusive through busy
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        for (int unsigned w = 0; w < ASSOC; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_SIZE'(w);
        end
      end
    end else if (busy) begin
      if (walk_clr_valid) valid_q[walk_set_q][walk_way_q] <= 1'b0;
      if (wb_fire)        dirty_q[walk_set_q][walk_way_q] <= 1'b0;
    end else begin
      if (bus.invalidate) begin
        valid_q[bus.set][sel_way] <= 1'b0;
        dirty_q[bus.set][sel_way] <= 1'b0;
      end else if (bus.install) begin
        valid_q[bus.set][sel_way] <= 1'b1;
        if (READ_ONLY == 0) dirty_q[bus.set][sel_way] <= install_dirty_val;
      end else if (READ_ONLY == 0) begin
        if (bus.clear_dirty)    dirty_q[bus.set][sel_way] <= 1'b0;
        else if (bus.set_dirty) dirty_q[bus.set][sel_way] <= 1'b1;
      end
      if (bus.touch) begin
        for (int unsigned w = 0; w < ASSOC; w++) begin
          if (WAY_SIZE'(w) == sel_way)          age_q[bus.set][w] <= '0;
          else if (age_q[bus.set][w] < touch_age) age_q[bus.set][w] <= age_q[bus.set][w] + WAY_SIZE'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !busy && !bus.invalidate && bus.install)
      tag_q[bus.set][sel_way] <= bus.tag;
  end

`ifdef METADATA_FLUSH_STATS_EN
  logic [SET_SIZE+WAY_SIZE:0] wb_count_q, wb_count_d;

  always_comb begin
    wb_count_d = wb_count_q;
    if (flush_start)  wb_count_d = '0;
    else if (wb_fire) wb_count_d = wb_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) wb_count_q <= '0;
    else       wb_count_q <= wb_count_d;
  end

  assign bus.flush_wb_count = wb_count_q;
`endif
endmodule

// File: tb/tb_cache_metadata_flush.sv
// Bench for cache_metadata_flush: vector table, LRU-list reference model with
// random traffic, and hand-built flush/reset sequences.
module tb_cache_metadata_flush;
  localparam int NS = 16;
  localparam int NA = 4;
  localparam int TW = 26;
  localparam int SS = 4;
  localparam int WS = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_metadata_flush_if #(.NUM_SETS(NS), .ASSOC(NA), .TAG_SIZE(TW)) bus ();
  cache_metadata_flush #(.NUM_SETS(NS), .ASSOC(NA), .TAG_SIZE(TW), .READ_ONLY(0)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: recency list per set (rank 0 = most recently used)
  bit              mv   [NS][NA];
  bit              md   [NS][NA];
  logic [TW-1:0]   mt   [NS][NA];
  int unsigned     mrec [NS][NA];

  function automatic void m_reset();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NA; w++) begin
        mv[s][w] = 0; md[s][w] = 0; mrec[s][w] = w;
      end
  endfunction

  function automatic int unsigned m_victim(input int unsigned s);
    for (int w = 0; w < NA; w++) if (!mv[s][w]) return w;
    return mrec[s][NA-1];
  endfunction

  function automatic void m_lookup(input int unsigned s, input int unsigned tg, input bit mrm,
                                   output bit h, output int unsigned sel);
    int unsigned hw;
    h = 0; hw = 0;
    for (int w = 0; w < NA; w++)
      if (mv[s][w] && mt[s][w] == TW'(tg)) begin h = 1; hw = w; end
    sel = mrm ? m_victim(s) : (h ? hw : 0);
  endfunction

  function automatic void m_touch(input int unsigned s, input int unsigned w);
    int p = 0;
    for (int i = 0; i < NA; i++) if (mrec[s][i] == w) p = i;
    for (int i = p; i > 0; i--) mrec[s][i] = mrec[s][i-1];
    mrec[s][0] = w;
  endfunction

  function automatic void m_apply(input int unsigned s, input int unsigned tg,
                                  input bit mrm, t, ins, idy, inv, sd, cd);
    bit h; int unsigned sel;
    m_lookup(s, tg, mrm, h, sel);
    if (inv) begin mv[s][sel] = 0; md[s][sel] = 0; end
    else if (ins) begin mv[s][sel] = 1; mt[s][sel] = TW'(tg); md[s][sel] = cd ? 0 : (idy | sd); end
    else if (cd) md[s][sel] = 0;
    else if (sd) md[s][sel] = 1;
    if (t) m_touch(s, sel);
  endfunction

  function automatic void m_all_invalid();
    for (int s = 0; s < NS; s++) for (int w = 0; w < NA; w++) mv[s][w] = 0;
  endfunction

  task automatic drv(input int unsigned s, input int unsigned tg, input bit mrm, t, ins, idy, inv, sd, cd);
    bus.set = SS'(s); bus.tag = TW'(tg); bus.miss_recovery_mode = mrm;
    bus.touch = t; bus.install = ins; bus.install_dirty = idy;
    bus.invalidate = inv; bus.set_dirty = sd; bus.clear_dirty = cd;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.flush_req = 0; bus.flush_wb_ready = 0;
  endtask

  task automatic do_reset();
    reset = 1; idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    m_reset();
  endtask

  // One controller cycle checked against the model, then applied to it
  task automatic step(input int unsigned s, input int unsigned tg, input bit mrm, t, ins, idy, inv, sd, cd);
    bit h; int unsigned sel;
    drv(s, tg, mrm, t, ins, idy, inv, sd, cd);
    @(negedge clk);
    m_lookup(s, tg, mrm, h, sel);
    chk("lk_match", bus.valid_block_match, h);
    chk("lk_way",   bus.selected_way, sel);
    chk("lk_dirty", bus.valid_dirty_bit, mv[s][sel] & md[s][sel]);
    if (mv[s][sel]) chk("lk_tag", bus.selected_tag, mt[s][sel]);
    chk("lk_busy", bus.flush_busy, 0);
    m_apply(s, tg, mrm, t, ins, idy, inv, sd, cd);
    @(posedge clk); #1;
  endtask

  task automatic rnd_step();
    int unsigned s, tg, sel; bit mrm, ins, h;
    s = $urandom_range(0, 3); tg = $urandom_range(1, 6); mrm = 1'($urandom_range(0, 1));
    ins = ($urandom_range(0, 2) == 0);
    m_lookup(s, tg, mrm, h, sel);
    if (h && mrm) ins = 0;  // keep tags unique within a set
    step(s, tg, mrm, 1'($urandom_range(0, 1)), ins, 1'($urandom_range(0, 1)),
         ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
  endtask

  typedef struct {int unsigned s, tg, wy;} line_t;

  task automatic flush_rand();
    line_t q[$]; line_t e; bit got_done = 0; int n_exp;
    for (int s = 0; s < NS; s++) for (int w = 0; w < NA; w++)
      if (mv[s][w] && md[s][w]) begin e.s = s; e.wy = w; e.tg = mt[s][w]; q.push_back(e); end
    n_exp = q.size();
    idle(); bus.flush_req = 1;
    @(posedge clk); #1;
    bus.flush_req = 0;
    for (int c = 0; c < 3000 && !got_done; c++) begin
      bus.flush_wb_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.flush_wb_valid) begin
        if (q.size() == 0) chk("rf_extra_offer", 1, 0);
        else begin
          chk("rf_set", bus.flush_wb_set, q[0].s);
          chk("rf_way", bus.flush_wb_way, q[0].wy);
          chk("rf_tag", bus.flush_wb_tag, q[0].tg);
          if (bus.flush_wb_ready) begin md[q[0].s][q[0].wy] = 0; void'(q.pop_front()); end
        end
      end
      if (bus.flush_done) got_done = 1;
      @(posedge clk); #1;
    end
    bus.flush_wb_ready = 0;
    chk("rf_done_seen", got_done, 1);
    chk("rf_offers_left", q.size(), 0);
`ifdef METADATA_FLUSH_STATS_EN
    chk("rf_wb_count", bus.flush_wb_count, n_exp);
`endif
    m_all_invalid();
  endtask

  typedef struct {
    int unsigned s, tg;
    bit mrm, t, ins, idy, inv, sd, cd;
    bit e_m, e_d;
    int unsigned e_w;
  } vec_t;
  vec_t vt[18];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found; int cnt, dcnt;
    do_reset();

    @(negedge clk);
    chk("rst_busy", bus.flush_busy, 0);
    chk("rst_wb_valid", bus.flush_wb_valid, 0);
    chk("rst_done", bus.flush_done, 0);
    chk("rst_wb_set", bus.flush_wb_set, 0);
    chk("rst_wb_way", bus.flush_wb_way, 0);
    chk("rst_wb_tag", bus.flush_wb_tag, 0);
`ifdef METADATA_FLUSH_STATS_EN
    chk("rst_wb_count", bus.flush_wb_count, 0);
`endif
    @(posedge clk); #1;

    //        set tag    mrm t ins idy inv sd cd   match dirty way
    vt[0]  = '{3, 'h55, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    vt[1]  = '{5, 'hA,  1, 1, 1, 0, 0, 0, 0,  0, 0, 0};
    vt[2]  = '{5, 'hB,  1, 1, 1, 0, 0, 0, 0,  0, 0, 1};
    vt[3]  = '{5, 'hC,  1, 1, 1, 0, 0, 0, 0,  0, 0, 2};
    vt[4]  = '{5, 'hD,  1, 1, 1, 0, 0, 0, 0,  0, 0, 3};
    vt[5]  = '{5, 'hA,  0, 1, 0, 0, 0, 0, 0,  1, 0, 0};
    vt[6]  = '{5, 'hE,  1, 0, 0, 0, 0, 0, 0,  0, 0, 1};
    vt[7]  = '{5, 'hC,  0, 0, 0, 0, 0, 0, 0,  1, 0, 2};
    vt[8]  = '{2, 'h77, 1, 0, 1, 1, 1, 0, 0,  0, 0, 0};
    vt[9]  = '{2, 'h77, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    vt[10] = '{2, 'h77, 1, 0, 1, 1, 0, 0, 0,  0, 0, 0};
    vt[11] = '{2, 'h77, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0};
    vt[12] = '{2, 'h77, 0, 0, 0, 0, 0, 1, 1,  1, 1, 0};
    vt[13] = '{2, 'h77, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0};
    vt[14] = '{4, 'h99, 1, 0, 1, 0, 0, 1, 0,  0, 0, 0};
    vt[15] = '{4, 'h99, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0};
    vt[16] = '{4, 'h99, 0, 0, 0, 0, 1, 0, 0,  1, 1, 0};
    vt[17] = '{4, 'h99, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0};
    for (int i = 0; i < 18; i++) begin
      drv(vt[i].s, vt[i].tg, vt[i].mrm, vt[i].t, vt[i].ins, vt[i].idy, vt[i].inv, vt[i].sd, vt[i].cd);
      @(negedge clk);
      chk($sformatf("vec%0d_match", i), bus.valid_block_match, vt[i].e_m);
      chk($sformatf("vec%0d_dirty", i), bus.valid_dirty_bit, vt[i].e_d);
      chk($sformatf("vec%0d_way", i),   bus.selected_way, vt[i].e_w);
      m_apply(vt[i].s, vt[i].tg, vt[i].mrm, vt[i].t, vt[i].ins, vt[i].idy, vt[i].inv, vt[i].sd, vt[i].cd);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 300; i++) rnd_step();
    flush_rand();
    for (int i = 0; i < 150; i++) rnd_step();
    flush_rand();

    // Stalled writeback with strobes and flush_req issued while busy
    do_reset();
    step(1, 'h101, 1, 1, 1, 0, 0, 0, 0);
    step(1, 'h102, 1, 1, 1, 0, 0, 0, 0);
    step(1, 'h103, 1, 1, 1, 1, 0, 0, 0);
    step(9, 'h901, 1, 1, 1, 1, 0, 0, 0);
    idle(); bus.flush_req = 1;
    @(posedge clk); #1;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (c % 2 == 0) drv(0, 'h123, 1, 1, 1, 1, 0, 0, 0);
      else            drv(9, 'h901, 0, 1, 0, 0, 1, 1, 0);
      bus.flush_req = 1;
      @(negedge clk);
      if (c == 0) chk("fa_busy_after_req", bus.flush_busy, 1);
      if (c % 2 == 1) chk("fa_match_forced0", bus.valid_block_match, 0);
      if (bus.flush_wb_valid) found = 1;
      else begin @(posedge clk); #1; end
    end
    chk("fa_offer1_seen", found, 1);
    chk("fa_offer1_set", bus.flush_wb_set, 1);
    chk("fa_offer1_way", bus.flush_wb_way, 2);
    chk("fa_offer1_tag", bus.flush_wb_tag, 'h103);
    @(posedge clk); #1;
    idle();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("fa_stall_valid", bus.flush_wb_valid, 1);
      chk("fa_stall_set", bus.flush_wb_set, 1);
      chk("fa_stall_way", bus.flush_wb_way, 2);
      chk("fa_stall_tag", bus.flush_wb_tag, 'h103);
      @(posedge clk); #1;
    end
    bus.flush_wb_ready = 1;
    @(posedge clk); #1;
    bus.flush_wb_ready = 0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (bus.flush_wb_valid) found = 1;
      else chk("fa_no_early_done", bus.flush_done, 0);
      @(posedge clk); #1;
    end
    chk("fa_offer2_seen", found, 1);
    chk("fa_offer2_set", bus.flush_wb_set, 9);
    chk("fa_offer2_way", bus.flush_wb_way, 0);
    chk("fa_offer2_tag", bus.flush_wb_tag, 'h901);
    bus.flush_wb_ready = 1;
    @(posedge clk); #1;
    bus.flush_wb_ready = 0;
    dcnt = 0; found = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (bus.flush_done) begin
        dcnt++;
        if (!found) chk("fa_busy_at_done", bus.flush_busy, 0);
        found = 1;
      end
      if (found && c > 0 && !bus.flush_done && bus.flush_busy) chk("fa_restarted", bus.flush_busy, 0);
      @(posedge clk); #1;
      if (found && dcnt == 1 && !bus.flush_done && c > 110) break;
    end
    chk("fa_done_pulses", dcnt, 1);
`ifdef METADATA_FLUSH_STATS_EN
    chk("fa_wb_count", bus.flush_wb_count, 2);
`endif
    m_all_invalid();
    md[1][2] = 0; md[9][0] = 0;
    step(1, 'h101, 0, 0, 0, 0, 0, 0, 0);
    step(1, 'h103, 0, 0, 0, 0, 0, 0, 0);
    step(9, 'h901, 0, 0, 0, 0, 0, 0, 0);
    drv(0, 'h123, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("fa_install_ignored", bus.valid_block_match, 0);
    @(posedge clk); #1;

    // Minimum flush length with only clean lines
    do_reset();
    step(0, 'h11, 1, 1, 1, 0, 0, 0, 0);
    step(7, 'h22, 1, 1, 1, 0, 0, 0, 0);
    step(15, 'h33, 1, 1, 1, 0, 0, 0, 0);
    idle(); bus.flush_req = 1;
    @(posedge clk); #1;
    bus.flush_req = 0;
    cnt = 0; found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (bus.flush_busy) cnt++;
      else found = 1;
      if (bus.flush_wb_valid) chk("fb_unexpected_offer", 1, 0);
      if (!found) begin @(posedge clk); #1; end
    end
    chk("fb_scan_cycles", cnt, 64);
    chk("fb_done_after_scan", bus.flush_done, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fb_done_one_cycle", bus.flush_done, 0);
    @(posedge clk); #1;
    m_all_invalid();
    step(0, 'h11, 0, 0, 0, 0, 0, 0, 0);
    step(15, 'h33, 0, 0, 0, 0, 0, 0, 0);

    // Reset while a writeback is pending
    do_reset();
    step(0, 'h200, 1, 1, 1, 1, 0, 0, 0);
    idle(); bus.flush_req = 1;
    @(posedge clk); #1;
    bus.flush_req = 0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus.flush_wb_valid) found = 1;
      @(posedge clk); #1;
    end
    chk("fc_wb_reached", found, 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("fc_busy_after_rst", bus.flush_busy, 0);
    chk("fc_wbv_after_rst", bus.flush_wb_valid, 0);
    chk("fc_done_after_rst", bus.flush_done, 0);
`ifdef METADATA_FLUSH_STATS_EN
    chk("fc_count_after_rst", bus.flush_wb_count, 0);
`endif
    @(posedge clk); #1;
    m_reset();
    dcnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.flush_done) dcnt++;
      @(posedge clk); #1;
    end
    chk("fc_no_done_later", dcnt, 0);
    step(0, 'h200, 0, 0, 0, 0, 0, 0, 0);
    step(0, 'h200, 1, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
